// File: rtl/o232c_buffered.sv
// o232c_buffered: RS-232C 8N1 transmitter fed by a small circular byte FIFO.
// Bytes pushed by the core are queued and then sent LSB first as start, d0..d7,
// stop, with each bit held for WAIT clocks. Queued bytes go out back to back.
`timescale 1ns/1ps
module o232c_buffered #(
    parameter int WAIT      = 143,
    parameter int DEPTH_LOG = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       push,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG;
    localparam int                  BW        = $clog2(WAIT);
    localparam logic [BW-1:0]       BAUD_LAST = BW'(WAIT - 1);
    localparam logic [DEPTH_LOG:0]  CNT_FULL  = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 full_q, full_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 push_ok;
    logic                 pop;
    logic                 baud_end;

    // Next-state logic: FIFO bookkeeping, transmitter FSM and registered status flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        // A push is refused on the pre-edge full flag, even if a pop frees a slot.
        push_ok    = push & ~full_q;
        overflow_d = overflow_q | (push & full_q);
        baud_end   = (baud_q == BAUD_LAST);

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // shift_q[1] is the bit that lands in position 0 after this shift.
                        tx_d  = shift_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d = (count_d == CNT_FULL);
        busy_d = (state_d != IDLE) | (count_d != '0);
    end

    // Control registers with synchronous reset; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    // Datapath registers: shift register and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign tx       = tx_q;
    assign full     = full_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: doc/o232c_buffered.md
Name: o232c_buffered

Overview:
- RS-232C transmitter; the transmit-side counterpart of the i232c receiver.
- Accepts bytes from the core through a push interface and buffers them in a small FIFO.
- Serializes each byte as 8N1 on the tx line at a clock-divided baud rate.
- Sits between sram_top-side logic and the RS_TX pin; a bench checks its output by looping RS_TX into i232c.

Parameters:
- WAIT, 143, clocks per bit (143 × 14 ns ≈ 2000 ns per bit); legal range is ≥2.
- DEPTH_LOG, 4, log2 of FIFO depth (default 16 entries).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data  in  8  byte to transmit.
- push  in  1  write data into the FIFO this cycle.
- tx  out  1  serial line; idle high.
- full  out  1  FIFO holds 2^DEPTH_LOG entries.
- busy  out  1  FIFO non-empty or a frame in progress.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
Reset
- Sampled on a clk rising edge.
- Outputs after reset: tx=1, full=0, busy=0, overflow=0.
- FIFO pointers, count, baud counter and bit counter go to 0; state goes to IDLE.
- Reset mid-frame aborts the frame immediately; tx returns to 1 on the next edge and all buffered bytes are discarded.

FIFO
- Circular buffer, 2^DEPTH_LOG × 8 bits.
- Read/write pointers are DEPTH_LOG bits wide and wrap naturally.
- count is DEPTH_LOG+1 bits wide.
- full = (count == 2^DEPTH_LOG), registered.
- Push with full=1: byte dropped, overflow set, FIFO unchanged. This holds even if a pop occurs in the same cycle; full is evaluated from the pre-edge count.
- Push and pop in the same cycle with count not full: count unchanged, both pointers advance.
- Pop occurs only in the transmitter's load step.

Transmitter FSM: IDLE, START, DATA, STOP
- IDLE: tx=1. If count≠0 at the edge: pop the head into an 8-bit shift register, tx<=0, baud counter<=0, go to START.
- START: hold tx=0 for WAIT clocks. On baud counter == WAIT-1: tx<=shift[0], bit counter<=0, go to DATA.
- DATA: each bit is held WAIT clocks, LSB first. At the end of each bit: shift right; bit counter increments.
  - After bit 7: tx<=1, go to STOP.
  - Otherwise: tx<=next bit.
- STOP: hold tx=1 for WAIT clocks. At the end of the stop bit:
  - If count≠0: pop, tx<=0, go to START (back-to-back frames, no idle gap).
  - Otherwise: go to IDLE.
- tx is a registered output; no combinational path from inputs to tx.

Timing
- Push at edge N into an empty FIFO while IDLE → tx falls after edge N+1.
- Frame length is exactly 10×WAIT clocks: start, d0..d7, stop.
- busy = (state≠IDLE) | (count≠0), registered. It rises the cycle after the push and falls on the same edge the FSM returns to IDLE.
- Data in the FIFO is held stable; input data is sampled only at a push edge.

Test Plan:
- Single byte, WAIT=4: push 0x4D once → tx low 4 clocks starting 1 edge after the push, then bits 1,0,1,1,0,0,1,0 each for 4 clocks, then high 4 clocks. busy is high for exactly 41 clocks. tx stays 1 afterwards.
- Back-to-back, WAIT=4: push 0x00 and 0xFF on consecutive cycles → frame 1 is start plus 8 zeros plus stop; its stop bit is followed immediately by the start of frame 2, then 8 ones and a stop. Total 80 clocks with no idle gap.
- Overflow, DEPTH_LOG=2, WAIT=4: push 0x01..0x06 on 6 consecutive cycles → first byte popped at cycle 2, so the FIFO holds 0x02..0x05. 0x06 arrives when full: dropped, overflow=1. Output frames are 0x01..0x05 only. overflow stays 1 until reset.
- Loopback, default WAIT=143, 14 ns clk: tx feeds an i232c instance; push 0x41, 0x42, 0x43 → i232c pulses changed 3 times with data 0x41, 0x42, 0x43 in order.
- Reset mid-frame, WAIT=4: push 0xA5 and 0x3C, assert reset during bit d3 of the first frame → tx=1 on the next edge, busy=0, full=0. No further frames appear. A subsequent push of 0x55 transmits cleanly.
- Push while the FSM pops with count=1, DEPTH_LOG=2: the simultaneous push and pop leave count at 1 → the next frame carries the new byte and full never asserts.
